// File: rtl/dft_arb.sv
// dft_arb: round-robin arbiter/sequencer sharing one 8-point DFT core between two requesters.
// Latency: dft_next in the handshake cycle, dft_x one cycle later; rsp_valid 2 cycles after dft_next_out.
// Backpressure: ready low outside IDLE, during reset and while the tag FIFO is full; no response backpressure.
module dft_arb #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int GAP   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [N*W-1:0]           req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [N*W-1:0]           req1_data,
  output logic                     dft_next,
  output logic [N*W-1:0]           dft_x,
  input  logic                     dft_next_out,
  input  logic [N*W-1:0]           dft_y,
  output logic                     rsp_valid,
  output logic                     rsp_id,
  output logic [N*W-1:0]           rsp_data,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             last_q, last_d;
  logic [N*W-1:0]   frame_q, frame_d;
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             cap_q, cap_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [N*W-1:0]   rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic full, empty, grant_ok, gnt_id, push, pop;

  // Arbitration: grant only from IDLE, out of reset, with room in the tag FIFO.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    grant_ok   = rst_n && (state_q == S_IDLE) && !full && (req0_valid || req1_valid);
    gnt_id     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    req0_ready = grant_ok && !gnt_id;
    req1_ready = grant_ok && gnt_id;
    dft_next   = grant_ok;
    dft_x      = (state_q == S_LOAD) ? frame_q : '0;
  end

  // Issue FSM: latch frame on handshake, present it for one cycle, then enforce the issue gap.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    last_d  = last_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          state_d = S_LOAD;
          last_d  = gnt_id;
          frame_d = gnt_id ? req1_data : req0_data;
        end
      end
      S_LOAD: begin
        if (GAP == 2) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
          gap_d   = GW'(GAP - 2);
        end
      end
      S_HOLD: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag FIFO and return path: capture result the cycle after next_out, pop the owning id with it.
  always_comb begin
    push        = grant_ok;
    pop         = cap_q && !empty;
    tag_d       = tag_q;
    if (push) tag_d[wr_ptr_q] = gnt_id;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    cap_d       = dft_next_out;
    rsp_valid_d = cap_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (cap_q) begin
      rsp_data_d = dft_y;
      rsp_id_d   = empty ? 1'b0 : tag_q[rd_ptr_q];
    end
    // A result with no matching tag means the core and this block disagree; keep it visible.
    err_d = err_q || (cap_q && empty);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      last_q      <= 1'b1;
      frame_q     <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cap_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      last_q      <= last_d;
      frame_q     <= frame_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = count_q;
  assign err       = err_q;

endmodule
